// File: rtl/serial_sub_48bit.sv
// serial_sub_48bit: 48-bit unsigned subtractor D = A - B - Bi, computed one
// SLICE-bit slice per clock from the LSB slice upward, with a borrow chained
// between slices. Control is a three-state FSM (IDLE, RUN, DONE).
// Optional feature macro: SUB_OVF_EN adds output V, the two's-complement
// overflow of A - B - Bi, valid with done.
// SLICE must be one of 8, 16, 24 or 48.
module serial_sub_48bit #(
    parameter int SLICE = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        Bi,
    input  logic [47:0] A,
    input  logic [47:0] B,
    output logic [47:0] D,
    output logic        Bo,
    output logic        busy,
`ifdef SUB_OVF_EN
    output logic        V,
`endif
    output logic        done
);

    localparam int NSL = 48 / SLICE;
    localparam int CW  = $clog2(NSL + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [47:0]     a_q, b_q, d_q;
    logic            brw_q, bo_q;
    logic [CW-1:0]   cnt_q;
    logic            last_slice;
    logic            capture;
    logic [SLICE:0]  sdiff;
`ifdef SUB_OVF_EN
    logic            v_q;
`endif

    // One slice of subtraction; the extra top bit of the result is the
    // slice borrow-out (set whenever a - b - bin went negative).
    function automatic logic [SLICE:0] sub_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             bin);
        sub_slice = {1'b0, a} - {1'b0, b} - {{SLICE{1'b0}}, bin};
    endfunction

    assign last_slice = (cnt_q == CW'(NSL - 1));
    // A start is honoured only when no operation is in flight.
    assign capture    = start && (state != RUN);
    assign sdiff      = sub_slice(a_q[cnt_q*SLICE +: SLICE],
                                  b_q[cnt_q*SLICE +: SLICE], brw_q);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = RUN;
            RUN:     if (last_slice) state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture and slice-serial datapath; results hold until the
    // next slice write, so D/Bo stay stable from DONE until a new run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            d_q   <= '0;
            brw_q <= 1'b0;
            bo_q  <= 1'b0;
            cnt_q <= '0;
`ifdef SUB_OVF_EN
            v_q   <= 1'b0;
`endif
        end else if (capture) begin
            a_q   <= A;
            b_q   <= B;
            brw_q <= Bi;
            cnt_q <= '0;
        end else if (state == RUN) begin
            d_q[cnt_q*SLICE +: SLICE] <= sdiff[SLICE-1:0];
            brw_q <= sdiff[SLICE];
            cnt_q <= cnt_q + CW'(1);
            if (last_slice) begin
                bo_q <= sdiff[SLICE];
`ifdef SUB_OVF_EN
                // Top result bit is produced in this same cycle.
                v_q  <= (a_q[47] != b_q[47]) && (sdiff[SLICE-1] != a_q[47]);
`endif
            end
        end
    end

    assign D    = d_q;
    assign Bo   = bo_q;
    assign busy = (state == RUN);
    assign done = (state == DONE);
`ifdef SUB_OVF_EN
    assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_sub_48bit.sv
// Self-checking bench for serial_sub_48bit: directed vector table, reset and
// back-to-back sequences, then randomized operands against an arithmetic model.
module tb_serial_sub_48bit;

    localparam int SLICE = 8;
    localparam int NSL   = 48 / SLICE;

    logic        clk = 1'b0;
    logic        rst, start, Bi;
    logic [47:0] A, B, D;
    logic        Bo, busy, done;
`ifdef SUB_OVF_EN
    logic        V;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       nm;
        logic [47:0] a;
        logic [47:0] b;
        logic        bi;
        logic [47:0] d;
        logic        bo;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    serial_sub_48bit #(.SLICE(SLICE)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .Bi   (Bi),
        .A    (A),
        .B    (B),
        .D    (D),
        .Bo   (Bo),
        .busy (busy),
`ifdef SUB_OVF_EN
        .V    (V),
`endif
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: whole-word arithmetic, borrow by unsigned compare,
    // overflow by range check of the true signed difference.
    function automatic vec_t model(input string nm, input logic [47:0] a,
                                   input logic [47:0] b, input logic bi);
        vec_t r;
        longint sa, sb, s;
        r.nm = nm;
        r.a  = a;
        r.b  = b;
        r.bi = bi;
        r.d  = a - b - 48'(bi);
        r.bo = ({1'b0, a} < ({1'b0, b} + 49'(bi)));
        sa   = longint'({{16{a[47]}}, a});
        sb   = longint'({{16{b[47]}}, b});
        s    = sa - sb - longint'(bi);
        r.v  = (s > 64'sh0000_7FFF_FFFF_FFFF) || (s < -64'sh0000_8000_0000_0000);
        return r;
    endfunction

    task automatic issue(input vec_t t);
        A = t.a; B = t.b; Bi = t.bi; start = 1'b1;
        step();
        start = 1'b0;
        // Scramble inputs after capture; the result must not follow them.
        A  = {16'($urandom), $urandom};
        B  = {16'($urandom), $urandom};
        Bi = 1'($urandom);
    endtask

    task automatic wait_done(input string nm);
        int lat;
        lat = 0;
        while (done !== 1'b1 && lat < NSL + 10) begin
            step();
            lat++;
        end
        chk({nm, " latency"}, 64'(lat), 64'(NSL));
    endtask

    task automatic chk_out(input vec_t t);
        chk({t.nm, " D"}, D, t.d);
        chk({t.nm, " Bo"}, Bo, t.bo);
`ifdef SUB_OVF_EN
        chk({t.nm, " V"}, V, t.v);
`endif
    endtask

    task automatic do_op(input vec_t t);
        issue(t);
        chk({t.nm, " busy"}, busy, 1);
        wait_done(t.nm);
        chk_out(t);
        step();
        chk({t.nm, " done one cycle"}, done, 0);
        chk({t.nm, " D hold"}, D, t.d);
        chk({t.nm, " Bo hold"}, Bo, t.bo);
    endtask

    initial begin
        vec_t t, t2;
        int   pulses;

        vecs.push_back('{"sub_basic", 48'h0000_0000_0010, 48'h0000_0000_0001, 1'b0,
                         48'h0000_0000_000F, 1'b0, 1'b0});
        vecs.push_back('{"zero_minus_one", 48'h0, 48'h1, 1'b0,
                         48'hFFFF_FFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{"min_minus_one", 48'h8000_0000_0000, 48'h1, 1'b0,
                         48'h7FFF_FFFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{"borrow_chain", 48'h0000_0100_0000, 48'h0, 1'b1,
                         48'h0000_00FF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{"ones_bi", 48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b1,
                         48'hFFFF_FFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{"max_minus_neg1", 48'h7FFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF, 1'b0,
                         48'h8000_0000_0000, 1'b1, 1'b1});
        vecs.push_back('{"zeros", 48'h0, 48'h0, 1'b0, 48'h0, 1'b0, 1'b0});

        rst = 1'b0; start = 1'b0; Bi = 1'b0; A = '0; B = '0;
        step();
        step();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset D", D, 0);
        chk("reset Bo", Bo, 0);
        rst = 1'b1;
        step();

        // Directed table.
        for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

        // Second start mid-run, then reset: no effect, abort, no done.
        t  = model("abort", 48'h1234_5678_9ABC, 48'h0000_1111_2222, 1'b0);
        t2 = model("ignored", 48'hAAAA_AAAA_AAAA, 48'h5555_5555_5555, 1'b1);
        issue(t);
        step();
        step();
        A = t2.a; B = t2.b; Bi = t2.bi; start = 1'b1;
        step();
        start = 1'b0;
        chk("abort busy before rst", busy, 1);
        rst = 1'b0;
        step();
        chk("abort busy", busy, 0);
        chk("abort D", D, 0);
        chk("abort Bo", Bo, 0);
        chk("abort done", done, 0);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < NSL + 4; i++) begin
            step();
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("abort no done", 64'(pulses), 0);

        // Start while in reset is ignored; first capture when rst=1.
        t = model("post_reset", 48'h0000_0000_1000, 48'h0000_0000_0FFF, 1'b1);
        A = t.a; B = t.b; Bi = t.bi; start = 1'b1; rst = 1'b0;
        step();
        chk("start in reset", busy, 0);
        rst = 1'b1;
        step();
        start = 1'b0;
        chk("first capture", busy, 1);
        wait_done(t.nm);
        chk_out(t);
        step();

        // Back-to-back starts issued in the DONE cycle.
        t = model("b2b0", 48'h0000_0000_0005, 48'h0000_0000_0007, 1'b0);
        issue(t);
        for (int k = 1; k <= 3; k++) begin
            wait_done(t.nm);
            chk_out(t);
            t = model($sformatf("b2b%0d", k), {16'($urandom), $urandom},
                      {16'($urandom), $urandom}, 1'($urandom));
            issue(t);
            chk({t.nm, " done drop"}, done, 0);
            chk({t.nm, " busy"}, busy, 1);
        end
        wait_done(t.nm);
        chk_out(t);
        step();
        chk("b2b end done", done, 0);

        // Random operands, with occasional equal or saturated operands.
        for (int i = 0; i < 1000; i++) begin
            logic [47:0] ra, rb;
            ra = {16'($urandom), $urandom};
            rb = {16'($urandom), $urandom};
            case ($urandom_range(0, 9))
                0:       rb = ra;
                1:       ra = '1;
                2:       rb = '1;
                3:       ra = '0;
                default: ;
            endcase
            do_op(model($sformatf("rand%0d", i), ra, rb, 1'($urandom)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_sub_48bit.md
SERIAL_SUB_48BIT -- requirements
Module: serial_sub_48bit

Interface
REQ-001 SHALL have parameter SLICE, default 8, meaning bits processed per RUN cycle; legal values 8, 16, 24, 48 only.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; one clock, reset is synchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction.
REQ-005 SHALL have port Bi, input, 1, borrow in.
REQ-006 SHALL have ports A and B, input, 48, unsigned minuend and subtrahend.
REQ-007 SHALL have port D, output, 48, difference A - B - Bi mod 2^48.
REQ-008 SHALL have port Bo, output, 1, borrow out; 1 when A < B + Bi as unsigned values.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle pulse marking D and Bo valid.

Function
REQ-011 SHALL implement states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL capture A, B and Bi into internal registers, clear the slice counter, and enter RUN.
REQ-013 In IDLE, start=0 SHALL keep IDLE; in DONE, start=0 SHALL return to IDLE.
REQ-014 Each RUN cycle SHALL compute slice k: D[k*SLICE +: SLICE] = A_slice - B_slice - borrow, with borrow initialised to the captured Bi and updated to the slice borrow-out; slice 0 is the LSB slice.
REQ-015 After slice 48/SLICE-1 is written, the block SHALL enter DONE, with Bo equal to the final borrow.
REQ-016 Latency SHALL be fixed: with start sampled on edge n, done is high during the cycle after edge n+48/SLICE, i.e. 6 cycles for SLICE=8.
REQ-017 done SHALL be high only in DONE and for exactly one cycle per operation.
REQ-018 busy SHALL be high only in RUN.
REQ-019 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-020 Changes on A, B and Bi after capture SHALL not affect the result.
REQ-021 D and Bo SHALL hold their values from DONE until the next capture.
REQ-022 D slices not yet computed during RUN are undefined to the user and SHALL not be relied upon.
REQ-023 start in DONE SHALL begin back-to-back operation with no idle cycle, and done SHALL drop in the next cycle.

Reset
REQ-024 rst=0 at a rising edge SHALL force IDLE and clear D, Bo, busy, done, the slice counter, the borrow and the captured operands to 0; this applies in any state.
REQ-025 Reset asserted mid-RUN SHALL abort the operation, with no done pulse.
REQ-026 start SHALL be ignored while rst=0; the first capture is possible on the first edge with rst=1.

Configuration
REQ-027 Macro SUB_OVF_EN, when defined, SHALL add output V (1 bit), the two's-complement overflow of A - B - Bi.
REQ-028 V SHALL equal (A[47] != B[47]) && (D[47] != A[47]).
REQ-029 V SHALL be valid with done, hold with D, and reset to 0.
REQ-030 Without SUB_OVF_EN, port V and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Bench SHALL run A=48'h0000_0000_0010, B=48'h0000_0000_0001, Bi=0, start pulse -> done after 6 cycles, D=48'h0000_0000_000F, Bo=0.
REQ-032 Bench SHALL run A=0, B=1, Bi=0 -> D=48'hFFFF_FFFF_FFFF, Bo=1, and V=0 with SUB_OVF_EN.
REQ-033 Bench SHALL run A=48'h8000_0000_0000, B=1, Bi=0 -> D=48'h7FFF_FFFF_FFFF, Bo=0, and V=1 with SUB_OVF_EN.
REQ-034 Bench SHALL run A=48'h0000_0100_0000, B=0, Bi=1 -> D=48'h0000_00FF_FFFF, Bo=0, which checks borrow propagation across slices.
REQ-035 Bench SHALL start, pulse start again at cycle 3 with different operands, then rst=0 at cycle 4 -> second start ignored, busy=0 and D=0 after the reset edge, and no done pulse.
REQ-036 Bench SHALL issue back-to-back starts in the DONE cycle -> exactly one done pulse per operation, each 6 cycles apart, with correct D; then 1000 random operands checked against a reference subtraction.
